// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one image-ROM read port among NUM_REQ sprite
// renderers. It issues one grant per cycle, supports a burst lock so a single
// requester can stream a whole sprite row, and tags each read response with
// the requester id after a fixed ROM latency.
module sprite_rom_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ROM_LATENCY = 2
) (
    input  logic                            pixel_clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    output logic                            rom_en,
    input  logic [DATA_WIDTH-1:0]           rom_dout,
    output logic                            rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_data
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [ID_W-1:0]   owner_reg, owner_next;

    logic              rr_found;
    logic [ID_W-1:0]   rr_winner;
    int                rr_idx;

    logic [NUM_REQ-1:0]    gnt_raw;
    logic [ID_W-1:0]       win_id;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] win_addr;

    // Tag pipe: stage 0 is loaded on the accept edge, the last stage lines up
    // with rom_dout.
    logic                  vld_pipe [ROM_LATENCY+1];
    logic [ID_W-1:0]       id_pipe  [ROM_LATENCY+1];

    // Round-robin search: first asserted request at or after ptr, with wrap.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = (int'(ptr_reg) + k) % NUM_REQ;
            if (!rr_found && req[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = ID_W'(rr_idx);
            end
        end
    end

    // Next-state, pointer update and raw grant for the ARB/LOCKED FSM.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        gnt_raw    = '0;
        win_id     = rr_winner;
        case (state_reg)
            ARB: begin
                if (rr_found) begin
                    gnt_raw[rr_winner] = 1'b1;
                    ptr_next = (rr_winner == ID_W'(NUM_REQ - 1)) ? '0
                                                                 : rr_winner + ID_W'(1);
                    if (req_lock[rr_winner]) begin
                        state_next = LOCKED;
                        owner_next = rr_winner;
                    end
                end
            end
            LOCKED: begin
                // Only the owner may be granted; an unlocked beat is its last,
                // and an idle owner releases the port without a beat.
                win_id = owner_reg;
                if (req[owner_reg]) begin
                    gnt_raw[owner_reg] = 1'b1;
                    if (!req_lock[owner_reg]) begin
                        state_next = ARB;
                    end
                end else begin
                    state_next = ARB;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // While reset is held the grant is forced low regardless of req.
    assign gnt      = rst_n ? gnt_raw : '0;
    assign accept   = |gnt;
    assign win_addr = req_addr[int'(win_id)*ADDR_WIDTH +: ADDR_WIDTH];

    // FSM state, round-robin pointer and lock owner registers.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARB;
            ptr_reg   <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    // ROM request register; the address holds when no beat is accepted.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            rom_en   <= 1'b0;
        end else begin
            rom_en <= accept;
            if (accept) begin
                rom_addr <= win_addr;
            end
        end
    end

    // First tag stage captures {valid,id} of the accepted beat.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[0] <= 1'b0;
            id_pipe[0]  <= '0;
        end else begin
            vld_pipe[0] <= accept;
            id_pipe[0]  <= win_id;
        end
    end

    generate
        for (genvar gi = 1; gi <= ROM_LATENCY; gi++) begin : g_tag_pipe
            // Shift the tag one stage per cycle to track the ROM latency.
            always_ff @(posedge pixel_clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe[gi] <= 1'b0;
                    id_pipe[gi]  <= '0;
                end else begin
                    vld_pipe[gi] <= vld_pipe[gi-1];
                    id_pipe[gi]  <= id_pipe[gi-1];
                end
            end
        end
    endgenerate

    assign rsp_valid = vld_pipe[ROM_LATENCY];
    assign rsp_id    = id_pipe[ROM_LATENCY];
    assign rsp_data  = rom_dout;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: reset, single beat latency,
// round-robin order and wrap, burst lock and lock release on owner idle.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int AW      = 16;
    localparam int DW      = 8;

    logic                  pixel_clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_lock;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ-1:0]    gnt;
    logic [AW-1:0]         rom_addr;
    logic                  rom_en;
    logic [DW-1:0]         rom_dout;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [DW-1:0]         rsp_data;

    logic [DW-1:0]         rom_q1;
    logic [AW-1:0]         addr_tab [NUM_REQ];

    int pass_cnt  = 0;
    int check_cnt = 0;

    sprite_rom_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROM_LATENCY(2)
    ) dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_en    (rom_en),
        .rom_dout  (rom_dout),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return a[15:8] ^ a[7:0];
    endfunction

    // Two-cycle ROM model.
    always @(posedge pixel_clk) begin
        rom_q1   <= rom_fn(rom_addr);
        rom_dout <= rom_q1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic set_addrs();
        for (int i = 0; i < NUM_REQ; i++) req_addr[i*AW +: AW] = addr_tab[i];
    endtask

    initial begin
        addr_tab[0] = 16'h0102;
        addr_tab[1] = 16'h1357;
        addr_tab[2] = 16'h1234;
        addr_tab[3] = 16'hBEEF;
        rst_n    = 1'b0;
        req      = 4'b1111;
        req_lock = '0;
        req_addr = '0;
        set_addrs();

        // Reset state: requests present but grant forced low.
        tick();
        tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rom_en", 32'(rom_en), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rom_addr", 32'(rom_addr), 32'h0);
        req = '0;
        rst_n = 1'b1;
        tick();

        // Single requester 2, address 0x1234.
        req = 4'b0100;
        #1;
        chk("single_gnt", 32'(gnt), 32'h4);
        tick();
        req = '0;
        chk("single_rom_en", 32'(rom_en), 32'h1);
        chk("single_rom_addr", 32'(rom_addr), 32'h1234);
        tick();
        chk("single_idle_en", 32'(rom_en), 32'h0);
        chk("single_t2_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_id", 32'(rsp_id), 32'h2);
        chk("single_rsp_data", 32'(rsp_data), 32'h26);
        tick();
        chk("single_rsp_done", 32'(rsp_valid), 32'h0);

        // Wrap: ptr=3, req=0101 -> 0, 2, 0.
        req = 4'b0101;
        #1;
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("wrap_gnt1", 32'(gnt), 32'h4);
        tick();
        chk("wrap_gnt2", 32'(gnt), 32'h1);
        tick();
        // ptr is now 1; one beat from requester 3 brings it back to 0.
        req = 4'b1000;
        #1;
        chk("align_gnt3", 32'(gnt), 32'h8);
        tick();

        // All four requesters for 8 cycles from ptr=0.
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(1 << (k % 4)));
            if (k >= 1) begin
                chk($sformatf("rr_en%0d", k), 32'(rom_en), 32'h1);
                chk($sformatf("rr_addr%0d", k), 32'(rom_addr), 32'(addr_tab[(k-1) % 4]));
            end
            if (k >= 3) begin
                chk($sformatf("rr_vld%0d", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("rr_id%0d", k), 32'(rsp_id), 32'((k-3) % 4));
                chk($sformatf("rr_data%0d", k), 32'(rsp_data), 32'(rom_fn(addr_tab[(k-3) % 4])));
            end
            tick();
        end

        // Reset mid-stream with three beats in flight.
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_rom_en", 32'(rom_en), 32'h0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_rst_vld%0d", k), 32'(rsp_valid), 32'h0);
        end

        // Lock: move ptr to 1, then requester 1 streams 4 beats.
        req = 4'b0001;
        #1;
        chk("lock_pre_gnt0", 32'(gnt), 32'h1);
        tick();
        req      = 4'b1011;
        req_lock = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) req_lock = 4'b0000;
            #1;
            chk($sformatf("lock_gnt%0d", k), 32'(gnt), 32'h2);
            tick();
        end
        req = 4'b1001;
        #1;
        chk("lock_after_gnt", 32'(gnt), 32'h8);
        tick();

        // Owner idles while locked: no beat, then next requester per ptr.
        req      = 4'b1011;
        req_lock = 4'b0001;
        #1;
        chk("idle_lock_gnt0", 32'(gnt), 32'h1);
        tick();
        #1;
        chk("idle_locked_gnt", 32'(gnt), 32'h1);
        tick();
        req      = 4'b1010;
        req_lock = '0;
        #1;
        chk("idle_drop_gnt", 32'(gnt), 32'h0);
        tick();
        chk("idle_drop_en", 32'(rom_en), 32'h0);
        #1;
        chk("idle_next_gnt", 32'(gnt), 32'h2);
        tick();
        req = '0;
        chk("idle_next_en", 32'(rom_en), 32'h1);
        chk("idle_next_addr", 32'(rom_addr), 32'(addr_tab[1]));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
